// File: rtl/mem_bus_router.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_bus_router
// Brief    : Routes single-outstanding CPU native-port transactions to the
//            8 KB BRAM controller, a local LED register, a local bus status
//            register, or an unmapped-space error responder. All outputs are
//            registered.
// Options  : BUS_TIMEOUT_EN - when defined, abandons a BRAM request after
//            TIMEOUT_CYCLES cycles without bram_mem_ready and answers with
//            32'hDEAD_BEEF plus a sticky bus_error.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_router #(
    parameter int          BRAM_ADDR_BITS = 13,
    parameter logic [31:0] LED_ADDR       = 32'hF000_1000,
    parameter logic [31:0] STAT_ADDR      = 32'hF000_1004,
    parameter int          LED_WIDTH      = 8,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_mem_valid,
    output logic                 cpu_mem_ready,
    input  logic [31:0]          cpu_mem_addr,
    input  logic [31:0]          cpu_mem_wdata,
    input  logic [3:0]           cpu_mem_wstrb,
    output logic [31:0]          cpu_mem_rdata,
    output logic                 bram_mem_valid,
    input  logic                 bram_mem_ready,
    output logic [31:0]          bram_mem_addr,
    output logic [31:0]          bram_mem_wdata,
    output logic [3:0]           bram_mem_wstrb,
    input  logic [31:0]          bram_mem_rdata,
    output logic [LED_WIDTH-1:0] led,
    output logic                 bus_error
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_BRAM_REQ = 2'd1;
    localparam logic [1:0]  c_RESP     = 2'd2;
    localparam logic [31:0] c_ERR_DATA = 32'hDEAD_BEEF;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_cpu_ready_nxt;
    logic                 w_bram_valid_nxt;
    logic                 w_timeout;

    logic                 r_cpu_ready;
    logic [31:0]          r_rdata;
    logic                 r_bram_valid;
    logic [31:0]          r_bram_addr;
    logic [31:0]          r_bram_wdata;
    logic [3:0]           r_bram_wstrb;
    logic [LED_WIDTH-1:0] r_led;
    logic                 r_bus_error;
    logic [LED_WIDTH-1:0] w_led_wr;

    // Address decode; the two local registers match on the word address only
    wire logic w_is_write  = |cpu_mem_wstrb;
    wire logic w_hit_bram  = (cpu_mem_addr[31:BRAM_ADDR_BITS] == '0);
    wire logic w_hit_led   = (cpu_mem_addr[31:2] == LED_ADDR[31:2]);
    wire logic w_hit_stat  = (cpu_mem_addr[31:2] == STAT_ADDR[31:2]);

    // Byte-lane merge of write data into the LED register
    for (genvar i = 0; i < LED_WIDTH; i++) begin : g_led_bits
        assign w_led_wr[i] = cpu_mem_wstrb[i/8] ? cpu_mem_wdata[i] : r_led[i];
    end

`ifdef BUS_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Count cycles spent waiting in BRAM_REQ; cleared in every other state
    always_ff @(posedge clk) begin
        if (reset || (r_state != c_BRAM_REQ)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A completion in the final waiting cycle still wins over the timeout
    assign w_timeout = (r_state == c_BRAM_REQ) && !bram_mem_ready &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (cpu_mem_valid) begin
                    w_next_state = w_hit_bram ? c_BRAM_REQ : c_RESP;
                end
            end
            c_BRAM_REQ: begin
                if (bram_mem_ready || w_timeout) begin
                    w_next_state = c_RESP;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Handshake outputs are registered, so derive them from the next state
    always_comb begin
        w_cpu_ready_nxt  = (w_next_state == c_RESP);
        w_bram_valid_nxt = (w_next_state == c_BRAM_REQ);
    end

    // Datapath: request latch, local register accesses and response data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_ready  <= 1'b0;
            r_rdata      <= '0;
            r_bram_valid <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_wdata <= '0;
            r_bram_wstrb <= '0;
            r_led        <= '0;
            r_bus_error  <= 1'b0;
        end else begin
            r_cpu_ready  <= w_cpu_ready_nxt;
            r_bram_valid <= w_bram_valid_nxt;
            case (r_state)
                c_IDLE: begin
                    if (cpu_mem_valid) begin
                        if (w_hit_bram) begin
                            r_bram_addr  <= cpu_mem_addr;
                            r_bram_wdata <= cpu_mem_wdata;
                            r_bram_wstrb <= cpu_mem_wstrb;
                        end else if (w_hit_led) begin
                            if (w_is_write) begin
                                r_led   <= w_led_wr;
                                r_rdata <= '0;
                            end else begin
                                r_rdata <= 32'(r_led);
                            end
                        end else if (w_hit_stat) begin
                            if (w_is_write) begin
                                if (cpu_mem_wstrb[0] && cpu_mem_wdata[0]) begin
                                    r_bus_error <= 1'b0;
                                end
                                r_rdata <= '0;
                            end else begin
                                r_rdata <= {31'b0, r_bus_error};
                            end
                        end else begin
                            r_rdata     <= w_is_write ? 32'h0 : c_ERR_DATA;
                            r_bus_error <= 1'b1;
                        end
                    end
                end
                c_BRAM_REQ: begin
                    if (bram_mem_ready) begin
                        r_rdata <= (r_bram_wstrb == 4'b0000) ? bram_mem_rdata : 32'h0;
                    end else if (w_timeout) begin
                        r_rdata     <= c_ERR_DATA;
                        r_bus_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_mem_ready  = r_cpu_ready;
    assign cpu_mem_rdata  = r_rdata;
    assign bram_mem_valid = r_bram_valid;
    assign bram_mem_addr  = r_bram_addr;
    assign bram_mem_wdata = r_bram_wdata;
    assign bram_mem_wstrb = r_bram_wstrb;
    assign led            = r_led;
    assign bus_error      = r_bus_error;

endmodule
`default_nettype wire
